// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU sequencer over one external 1-bit slice (in_* request, out_* result/flags, slice_* slice bus)
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_ctr,
  input  logic             slice_r,
  input  logic             slice_cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a, b, fin_res;
  logic [WIDTH-2:0] res;
  logic [2:0] op;
  logic [CW-1:0] cnt;
  logic carry, arith, slt, ovf, less, run;
  always_comb begin
    run = state == RUN;
    arith = op[1:0] == 2'b10;
    slt = op == 3'b111;
    ovf = carry ^ slice_cout;
    less = slice_r ^ ovf;
    fin_res = slt ? {{(WIDTH-1){1'b0}}, less} : {slice_r, res};
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign slice_a = run & a[cnt];
  assign slice_b = run & b[cnt];
  assign slice_cin = run & carry;
  assign slice_ctr = !run ? 3'b000 : slt ? 3'b110 : op;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      carry <= 1'b0;
      a <= '0;
      b <= '0;
      op <= '0;
      res <= '0;
      out_result <= '0;
      out_zero <= 1'b0;
      out_carry <= 1'b0;
      out_ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a <= in_a;
      b <= in_b;
      op <= in_op;
      cnt <= '0;
      carry <= in_op[2];
      state <= RUN;
    end else if (run) begin
      carry <= slice_cout;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH-1)) begin
        state <= DONE;
        out_result <= fin_res;
        out_zero <= fin_res == '0;
        out_carry <= arith & slice_cout;
        out_ovf <= arith & ovf;
      end else res[cnt] <= slice_r;
    end else if (state == DONE && out_ready) state <= IDLE;
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: scoreboard bench for alu_serial_ctrl with a behavioural 1-bit slice
module tb_alu_serial_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_zero, out_carry, out_ovf;
  logic [31:0] in_a = '0, in_b = '0, out_result;
  logic [2:0] in_op = '0, slice_ctr;
  logic slice_a, slice_b, slice_cin, slice_r, slice_cout, bn;
  typedef struct {logic [31:0] r; logic z, c, v;} exp_t;
  exp_t sb[$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  alu_serial_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
    .out_carry(out_carry), .out_ovf(out_ovf), .slice_a(slice_a),
    .slice_b(slice_b), .slice_cin(slice_cin), .slice_ctr(slice_ctr),
    .slice_r(slice_r), .slice_cout(slice_cout)
  );
  always_comb begin
    bn = slice_ctr[2] ? ~slice_b : slice_b;
    slice_r = 1'b0;
    slice_cout = 1'b0;
    case (slice_ctr)
      3'b000, 3'b100: slice_r = slice_a & bn;
      3'b001, 3'b101: slice_r = slice_a | bn;
      3'b011: slice_r = slice_a ^ slice_b;
      3'b010, 3'b110: begin
        slice_r = slice_a ^ bn ^ slice_cin;
        slice_cout = (slice_a & bn) | (slice_a & slice_cin) | (bn & slice_cin);
      end
      default: ;
    endcase
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    exp_t e;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      3'b000: e.r = a & b;
      3'b001: e.r = a | b;
      3'b011: e.r = a ^ b;
      3'b100: e.r = a & ~b;
      3'b101: e.r = a | ~b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        e.r = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b110: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.r = s[31:0];
        e.c = s[32];
        e.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      default: e.r = {31'b0, $signed(a) < $signed(b)};
    endcase
    e.z = e.r == 32'd0;
    return e;
  endfunction
  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input bit release_out, output exp_t e);
    accept(a, b, op);
    sb.push_back(model(a, b, op));
    for (int i = 0; i < 32; i++) begin
      check("slice_a", slice_a, a[i]);
      check("slice_b", slice_b, b[i]);
      check("slice_ctr", slice_ctr, op == 3'b111 ? 3'b110 : op);
      check("out_valid_early", out_valid, 0);
      if (i == 0) check("slice_cin0", slice_cin, op[2]);
      @(posedge clk);
      #1;
    end
    check("out_valid_latency", out_valid, 1);
    check("slice_idle", {slice_a, slice_b, slice_cin, slice_ctr}, 0);
    e = sb.pop_front();
    check("result", out_result, e.r);
    check("zero", out_zero, e.z);
    check("carry", out_carry, e.c);
    check("ovf", out_ovf, e.v);
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", {out_zero, out_carry, out_ovf}, 0);
    rst_n = 1'b1;
    run_op(32'h7FFFFFFF, 32'h1, 3'b010, 1, e);
    check("add_ovf_const", {e.r, e.v}, {32'h80000000, 1'b1});
    run_op(32'h5, 32'h5, 3'b110, 1, e);
    run_op(32'h0, 32'h1, 3'b110, 1, e);
    run_op(32'hFFFFFFFD, 32'h2, 3'b111, 1, e);
    run_op(32'h80000000, 32'h1, 3'b111, 1, e);
    run_op(32'h2, 32'h2, 3'b111, 1, e);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] ops [6] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b010};
      run_op(32'hF0F0F0F0, 32'hFF00FF00, ops[k], 1, e);
    end
    for (int k = 0; k < 4; k++) run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 1, e);
    run_op(32'h12345678, 32'h0F0F0F0F, 3'b011, 0, e);
    in_a = 32'hDEADBEEF;
    in_b = 32'h00000010;
    in_op = 3'b010;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_result", out_result, e.r);
      check("bp_flags", {out_zero, out_carry, out_ovf}, {e.z, e.c, e.v});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    check("bp_idle_holds_result", out_result, e.r);
    run_op(32'hDEADBEEF, 32'h00000010, 3'b010, 1, e);
    accept(32'hFFFF0000, 32'h0000FFFF, 3'b010);
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_running", {in_ready, out_valid}, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_flags", {out_zero, out_carry, out_ovf}, 0);
    check("mid_rst_slice", {slice_a, slice_b, slice_cin, slice_ctr}, 0);
    run_op(32'h3, 32'h4, 3'b010, 1, e);
    check("add_3_4_const", e.r, 32'h7);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that runs a WIDTH-bit ALU operation through one external 1-bit ALU slice, LSB first, one bit per clock. It holds the carry chain in a flop, collects result bits, and derives zero/carry/overflow. It also synthesises SLT from a serial subtract. It lets area-constrained datapaths (multi-cycle units, test datapaths) share a single slice instead of a WIDTH-slice ripple ALU.

Parameters:
WIDTH, 32, operand/result width in bits (min 2); counter width is clog2(WIDTH), derived internally.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  controller can accept a request (IDLE only).
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_op  input  3  alu_ctr encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 110 SUB, 111 SLT, 100 ANDN (a&~b), 101 ORN (a|~b).
out_valid  output  1  result available (DONE).
out_ready  input  1  consumer accepts result.
out_result  output  WIDTH  final result.
out_zero  output  1  out_result == 0.
out_carry  output  1  final carry out (ADD/SUB only, else 0).
out_ovf  output  1  signed overflow (ADD/SUB only, else 0).
slice_a  output  1  A bit to slice.
slice_b  output  1  B bit to slice.
slice_cin  output  1  carry into slice.
slice_ctr  output  3  slice control.
slice_r  input  1  slice result bit (combinational from slice_* outputs).
slice_cout  input  1  slice carry out.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, bit counter 0, carry flop 0, out_result/out_zero/out_carry/out_ovf = 0, out_valid 0, in_ready 1. Applies in any state and aborts any operation in flight; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_a, in_b, in_op. Set cnt=0 and carry=in_op[2]. For SLT, carry=1 (subtract). Go to RUN.
- RUN:
  - slice_a=a[cnt], slice_b=b[cnt], slice_cin=carry.
  - slice_ctr=op, except SLT drives 110.
  - Each edge: res[cnt]<=slice_r, carry<=slice_cout, cnt<=cnt+1.
  - When cnt==WIDTH-1: also record c_msb_in=carry (pre-update) and final cout=slice_cout. Go to DONE.
  - in_ready=0; in_valid ignored.
- DONE:
  - out_valid=1; all outputs are stable and held while out_ready=0.
  - On out_ready: go to IDLE. The next request can be accepted in the following cycle (no same-cycle turnaround).
- Outside RUN: slice_a=slice_b=slice_cin=0, slice_ctr=000.
- Latency: request accepted at edge k gives out_valid=1 after edge k+WIDTH. Throughput is one op per WIDTH+2 cycles with out_ready held high.
- Flags, computed at the RUN->DONE edge:
  - ADD/SUB: out_carry=final cout; out_ovf=c_msb_in XOR cout.
  - SUB carry=1 means no borrow.
  - Logic ops (AND, OR, XOR, ANDN, ORN): out_carry=0, out_ovf=0.
  - SLT: less = res[WIDTH-1] XOR (c_msb_in XOR cout); out_result={0...,less}; out_carry=0, out_ovf=0.
  - out_zero always reflects the final out_result, including SLT.
- Output registers update only at the RUN->DONE edge or on reset. They keep the last result while in IDLE, but out_valid=0 there.

Test Plan:
- ADD, WIDTH=32, a=0x7FFFFFFF, b=0x00000001 -> out_result=0x80000000, ovf=1, carry=0, zero=0; out_valid rises exactly 32 edges after accept.
- SUB, a=b=0x00000005 -> result=0, zero=1, carry=1, ovf=0. SUB 0-1 -> 0xFFFFFFFF, carry=0, ovf=0.
- SLT cases:
  - a=0xFFFFFFFD, b=0x00000002 -> result=1.
  - a=0x80000000, b=0x00000001 (subtract overflows) -> result=1.
  - a=2, b=2 -> result=0, zero=1.
  - Check slice_ctr=110 throughout RUN.
- Logic ops on a=0xF0F0F0F0, b=0xFF00FF00:
  - AND=0xF000F000, OR=0xFFF0FFF0, XOR=0x0FF00FF0, ANDN=0x00F000F0.
  - carry=ovf=0 for all.
  - Slice bus matches a[cnt]/b[cnt] each RUN cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0, nothing accepted. Then raise out_ready -> IDLE, and the new op is accepted on the next cycle.
- Reset mid-RUN at cnt=10 -> after the next edge: IDLE, in_ready=1, out_valid=0, all result/flag outputs 0. A subsequent ADD 3+4 gives 7.
